matmul_sequencer: RTL and testbench



---
 rtl/matmul_ctrl_pkg.sv | 25 ++
 rtl/mm_loop_counter.sv | 57 +++++
 rtl/matmul_sequencer.sv | 145 ++++++++++++++
 tb/tb_matmul_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_ctrl_pkg.sv
// Shared definitions for the matrix-multiplier control path: FSM states,
// register-select codes for the enable decoder, and the loop index width.
package matmul_ctrl_pkg;

   localparam int IDX_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CLR  = 3'd1,
      ST_RD_A = 3'd2,
      ST_LD_A = 3'd3,
      ST_LD_B = 3'd4,
      ST_MAC  = 3'd5,
      ST_WR   = 3'd6,
      ST_DONE = 3'd7
   } state_t;

   localparam logic [2:0] SEL_NOP  = 3'b000;
   localparam logic [2:0] SEL_LD_A = 3'b001;
   localparam logic [2:0] SEL_LD_B = 3'b010;
   localparam logic [2:0] SEL_MAC  = 3'b011;
   localparam logic [2:0] SEL_CLR  = 3'b100;
   localparam logic [2:0] SEL_ST_C = 3'b101;

endpackage

// File: rtl/mm_loop_counter.sv
// Three-level nested i/j/k counter for the matrix-multiply loop nest.
// k is the inner reduction index; inc_jk advances to the next C element
// (j fastest, then i). i holds at its last value after the final element.
module mm_loop_counter
   import matmul_ctrl_pkg::*;
#(
   parameter int DIM = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_all,
   input  logic             clr_k,
   input  logic             inc_k,
   input  logic             inc_jk,
   output logic [IDX_W-1:0] i_idx,
   output logic [IDX_W-1:0] j_idx,
   output logic [IDX_W-1:0] k_idx,
   output logic             last_k,
   output logic             last_j,
   output logic             last_i
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

   // Index registers: reset/new-run clear, k steps within an element, j/i step per element
   always_ff @(posedge clk) begin
      if (reset || clr_all) begin
         i_idx <= '0;
         j_idx <= '0;
         k_idx <= '0;
      end else begin
         if (clr_k) begin
            k_idx <= '0;
         end else if (inc_k) begin
            k_idx <= k_idx + 1'b1;
         end
         if (inc_jk) begin
            if (j_idx != LAST) begin
               j_idx <= j_idx + 1'b1;
            end else begin
               j_idx <= '0;
               if (i_idx != LAST) begin
                  i_idx <= i_idx + 1'b1;
               end
            end
         end
      end
   end

   // Terminal-count flags used by the sequencer to leave each loop level
   always_comb begin
      last_k = (k_idx == LAST);
      last_j = (j_idx == LAST);
      last_i = (i_idx == LAST);
   end

endmodule

// File: rtl/matmul_sequencer.sv
// Control unit for the matrix-multiplier datapath: walks C = A x B one
// element at a time, presenting A/B read addresses one cycle ahead of the
// register loads (1-cycle memory latency) and storing AC into C.
// All outputs are decoded from registered state and loop indices.
module matmul_sequencer
   import matmul_ctrl_pkg::*;
#(
   parameter int DIM    = 3,
   parameter int AW     = 8,
   parameter int A_BASE = 0,
   parameter int B_BASE = 9,
   parameter int C_BASE = 18
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    mem_addr,
   output logic             mem_we,
   output logic [2:0]       wr_sel,
   output logic [IDX_W-1:0] row_idx,
   output logic [IDX_W-1:0] col_idx
);

   state_t           state_q;
   state_t           state_d;
   logic [IDX_W-1:0] i_idx;
   logic [IDX_W-1:0] j_idx;
   logic [IDX_W-1:0] k_idx;
   logic             last_k;
   logic             last_j;
   logic             last_i;
   logic             clr_all;
   logic             clr_k;
   logic             inc_k;
   logic             inc_jk;
   logic [AW-1:0]    addr_a;
   logic [AW-1:0]    addr_b;
   logic [AW-1:0]    addr_c;

   mm_loop_counter #(
      .DIM (DIM)
   ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_all (clr_all),
      .clr_k   (clr_k),
      .inc_k   (inc_k),
      .inc_jk  (inc_jk),
      .i_idx   (i_idx),
      .j_idx   (j_idx),
      .k_idx   (k_idx),
      .last_k  (last_k),
      .last_j  (last_j),
      .last_i  (last_i)
   );

   // State register; reset wins over everything and abandons any run in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Row-major address generation, wrapping modulo 2^AW
   always_comb begin
      addr_a = AW'(A_BASE) + AW'(i_idx) * AW'(DIM) + AW'(k_idx);
      addr_b = AW'(B_BASE) + AW'(k_idx) * AW'(DIM) + AW'(j_idx);
      addr_c = AW'(C_BASE) + AW'(i_idx) * AW'(DIM) + AW'(j_idx);
   end

   // Next-state, loop-counter control and Moore output decode
   always_comb begin
      state_d  = state_q;
      clr_all  = 1'b0;
      clr_k    = 1'b0;
      inc_k    = 1'b0;
      inc_jk   = 1'b0;
      wr_sel   = SEL_NOP;
      mem_we   = 1'b0;
      mem_addr = '0;
      busy     = 1'b1;
      done     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               clr_all = 1'b1;
               state_d = ST_CLR;
            end
         end
         ST_CLR: begin
            wr_sel  = SEL_CLR;
            clr_k   = 1'b1;
            state_d = ST_RD_A;
         end
         ST_RD_A: begin
            mem_addr = addr_a;
            state_d  = ST_LD_A;
         end
         ST_LD_A: begin
            wr_sel   = SEL_LD_A;
            mem_addr = addr_b;
            state_d  = ST_LD_B;
         end
         ST_LD_B: begin
            wr_sel  = SEL_LD_B;
            state_d = ST_MAC;
         end
         ST_MAC: begin
            wr_sel = SEL_MAC;
            if (last_k) begin
               state_d = ST_WR;
            end else begin
               inc_k   = 1'b1;
               state_d = ST_RD_A;
            end
         end
         ST_WR: begin
            wr_sel   = SEL_ST_C;
            mem_we   = 1'b1;
            mem_addr = addr_c;
            inc_jk   = 1'b1;
            state_d  = (last_j && last_i) ? ST_DONE : ST_CLR;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Current element indices are exposed directly for the datapath/debug
   always_comb begin
      row_idx = i_idx;
      col_idx = j_idx;
   end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: a memory + datapath model around a DIM=3
// instance, plus a DIM=1 instance for the single-element corner case.
module tb_matmul_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       start1 = 1'b0;
   logic       do_load = 1'b0;

   logic       busy, done, mem_we;
   logic [7:0] mem_addr;
   logic [2:0] wr_sel;
   logic [3:0] row_idx, col_idx;

   logic       busy1, done1, mem_we1;
   logic [7:0] mem_addr1;
   logic [2:0] wr_sel1;
   logic [3:0] row_idx1, col_idx1;

   logic [21:0] ov3, ov1;

   int mem [256];
   int init_mem [256];
   int rdata, ar, br, ac;
   int wr_cnt = 0;
   int done_cnt = 0;
   int c_ref [9];
   logic [21:0] exp_q [$];

   int checks = 0;
   int errors = 0;

   matmul_sequencer #(.DIM(3), .AW(8), .A_BASE(0), .B_BASE(9), .C_BASE(18)) u_dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_we(mem_we), .wr_sel(wr_sel),
      .row_idx(row_idx), .col_idx(col_idx)
   );

   matmul_sequencer #(.DIM(1), .AW(8), .A_BASE(0), .B_BASE(1), .C_BASE(2)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
      .mem_addr(mem_addr1), .mem_we(mem_we1), .wr_sel(wr_sel1),
      .row_idx(row_idx1), .col_idx(col_idx1)
   );

   always #5 clk = ~clk;

   assign ov3 = {wr_sel, mem_we, mem_addr, busy, done, row_idx, col_idx};
   assign ov1 = {wr_sel1, mem_we1, mem_addr1, busy1, done1, row_idx1, col_idx1};

   // Memory with 1-cycle read latency and the AR/BR/AC datapath driven by wr_sel
   always @(posedge clk) begin
      if (do_load) begin
         for (int a = 0; a < 256; a++) mem[a] <= init_mem[a];
      end else begin
         rdata <= mem[mem_addr];
         case (wr_sel)
            3'b001: ar <= rdata;
            3'b010: br <= rdata;
            3'b011: ac <= ac + ar * br;
            3'b100: ac <= 0;
            default: ;
         endcase
         if (mem_we) begin
            mem[mem_addr] <= ac;
            wr_cnt <= wr_cnt + 1;
         end
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [21:0] ent(input int sel, input int we, input int addr,
                                       input int bsy, input int dn, input int r, input int c);
      return {sel[2:0], we[0], addr[7:0], bsy[0], dn[0], r[3:0], c[3:0]};
   endfunction

   // Expected per-cycle trace of the loop nest, written directly from the loop rules
   task automatic build(input int dim, input int ab, input int bb, input int cb);
      exp_q.delete();
      for (int i = 0; i < dim; i++) begin
         for (int j = 0; j < dim; j++) begin
            exp_q.push_back(ent(4, 0, 0, 1, 0, i, j));
            for (int k = 0; k < dim; k++) begin
               exp_q.push_back(ent(0, 0, (ab + i * dim + k) % 256, 1, 0, i, j));
               exp_q.push_back(ent(1, 0, (bb + k * dim + j) % 256, 1, 0, i, j));
               exp_q.push_back(ent(2, 0, 0, 1, 0, i, j));
               exp_q.push_back(ent(3, 0, 0, 1, 0, i, j));
            end
            exp_q.push_back(ent(5, 1, (cb + i * dim + j) % 256, 1, 0, i, j));
         end
      end
      exp_q.push_back(ent(0, 0, 0, 1, 1, dim - 1, 0));
   endtask

   // mode 0: A=1..9, B=identity; 1: all 2; 2: random
   task automatic load(input int mode);
      int a [3][3];
      int b [3][3];
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            case (mode)
               0: begin a[r][c] = r * 3 + c + 1; b[r][c] = (r == c) ? 1 : 0; end
               1: begin a[r][c] = 2; b[r][c] = 2; end
               default: begin a[r][c] = int'($urandom_range(0, 255)); b[r][c] = int'($urandom_range(0, 255)); end
            endcase
         end
      for (int x = 0; x < 256; x++) init_mem[x] = 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            init_mem[r * 3 + c] = a[r][c];
            init_mem[9 + r * 3 + c] = b[r][c];
            c_ref[r * 3 + c] = 0;
            for (int k = 0; k < 3; k++) c_ref[r * 3 + c] += a[r][k] * b[k][c];
         end
      @(negedge clk);
      do_load = 1'b1;
      @(negedge clk);
      do_load = 1'b0;
   endtask

   task automatic check_c(input string tag);
      for (int e = 0; e < 9; e++)
         check($sformatf("%s_c%0d", tag, e), mem[18 + e], c_ref[e]);
   endtask

   // One full run with cycle-by-cycle trace compare; optional stray start pulses
   task automatic run_check(input int dim, input int p1, input int p2);
      int wr0, d0;
      if (dim == 3) build(3, 0, 9, 18);
      else build(1, 0, 1, 2);
      wr0 = wr_cnt;
      d0 = done_cnt;
      @(negedge clk);
      if (dim == 3) start = 1'b1;
      else start1 = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      start1 = 1'b0;
      for (int n = 1; n <= exp_q.size(); n++) begin
         @(negedge clk);
         start = (n == p1 || n == p2);
         check($sformatf("trace_d%0d_cyc%0d", dim, n), (dim == 3) ? ov3 : ov1, exp_q[n - 1]);
      end
      @(negedge clk);
      start = 1'b0;
      check($sformatf("idle_after_d%0d", dim), (dim == 3) ? ov3[21:8] : ov1[21:8], 0);
      if (dim == 3) begin
         check("write_count", wr_cnt - wr0, 9);
         check("done_count", done_cnt - d0, 1);
      end
   endtask

   initial begin
      bit found;
      int wr_before;
      ar = 0; br = 0; ac = 0; rdata = 0;
      for (int x = 0; x < 256; x++) mem[x] = 0;

      // Reset then ten idle cycles: everything must stay at zero
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out", ov3, 0);
      reset = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         check($sformatf("idle%0d", n), {ov3, ov1}, 0);
      end

      // A = 1..9, B = identity
      load(0);
      run_check(3, 0, 0);
      check_c("ident");

      // A = B = 2 with ignored start pulses in cycles 5 and 60
      load(1);
      run_check(3, 5, 60);
      check_c("twos");

      // Random operands
      load(2);
      run_check(3, 0, 0);
      check_c("rand1");

      // Reset asserted during MAC of element (1,1)
      load(2);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 300 && !found; n++) begin
         @(negedge clk);
         if (wr_sel == 3'b011 && row_idx == 4'd1 && col_idx == 4'd1) found = 1'b1;
      end
      check("mac11_reached", found, 1);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_out", ov3, 0);
      reset = 1'b0;
      wr_before = wr_cnt;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check($sformatf("midreset_idle%0d", n), ov3, 0);
      end
      check("midreset_no_write", wr_cnt, wr_before);
      run_check(3, 0, 0);
      check_c("after_reset");

      // Single-element configuration
      run_check(1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
